tree_adder_operand_loader: RTL and testbench

- Upstream feeder for the 128-bit Sklansky tree adder.
- Collects two SIZE-bit operands from a narrow BEAT_W-bit valid/ready stream, LSB beat first, operand A then operand B.
- Presents the registered a/b/cin triple to the adder with an op_valid/op_ready handshake.
- Holds the triple stable until the downstream consumer accepts it.

---
 rtl/tree_adder_pkg.sv | 17 +
 rtl/tree_adder_operand_loader_beat_shift_slot.sv | 44 ++++
 rtl/tree_adder_operand_loader.sv | 172 +++++++++++++++++
 tb/tb_tree_adder_operand_loader.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_adder_pkg.sv
// Shared types and constants for the tree adder operand loader.
package tree_adder_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_e;

  localparam int DEFAULT_SIZE   = 128;
  localparam int DEFAULT_BEAT_W = 32;

  function automatic int beats_of(input int size, input int beat_w);
    return size / beat_w;
  endfunction

endpackage

// File: rtl/tree_adder_operand_loader_beat_shift_slot.sv
// Register bank of BEATS slices of BEAT_W bits, written one slice at a time.
// Output is 1-based ([SIZE:1]) to match the adder's operand indexing.
module beat_shift_slot
  import tree_adder_pkg::*;
#(
  parameter int SIZE   = DEFAULT_SIZE,
  parameter int BEAT_W = DEFAULT_BEAT_W,
  parameter int BEATS  = beats_of(SIZE, BEAT_W),
  parameter int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [BEAT_W-1:0] wr_data,
  output logic [SIZE:1]     data
);

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_slice
      logic [BEAT_W-1:0] slice_q;
      logic [BEAT_W-1:0] slice_d;

      always_comb begin
        slice_d = slice_q;
        if (wr_en && (wr_idx == IDX_W'(gi))) begin
          slice_d = wr_data;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          slice_q <= '0;
        end else begin
          slice_q <= slice_d;
        end
      end

      assign data[(gi+1)*BEAT_W : gi*BEAT_W+1] = slice_q;
    end
  endgenerate

endmodule

// File: rtl/tree_adder_operand_loader.sv
// Collects operands A then B from a narrow beat stream and presents them to the adder.
// Optional subtract mode enabled by defining TREE_ADDER_SUB_EN.
module tree_adder_operand_loader
  import tree_adder_pkg::*;
#(
  parameter int SIZE   = DEFAULT_SIZE,
  parameter int BEAT_W = DEFAULT_BEAT_W,
  localparam int BEATS  = beats_of(SIZE, BEAT_W),
  localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int BCNT_W = $clog2(BEATS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  input  logic              in_cin,
`ifdef TREE_ADDER_SUB_EN
  input  logic              in_sub,
`endif
  input  logic              flush,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [SIZE:1]     a,
  output logic [SIZE:1]     b,
  output logic              cin,
  output logic [BCNT_W-1:0] beat_cnt
);

  generate
    if ((SIZE % BEAT_W) != 0) begin : g_size_check
      $error("SIZE must be an integer multiple of BEAT_W");
    end
  endgenerate

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             cin_q, cin_d;
  logic             op_valid_q, op_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             accept;
  logic             a_wr, b_wr;
  logic [SIZE:1]    b_raw;

  // A flushed cycle never writes operand storage, so the dropped beat leaves no trace.
  assign accept = in_valid && in_ready_q && !flush;
  assign a_wr   = accept && (state_q == LOAD_A);
  assign b_wr   = accept && (state_q == LOAD_B);

`ifdef TREE_ADDER_SUB_EN
  logic sub_q, sub_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cin_d   = cin_q;
`ifdef TREE_ADDER_SUB_EN
    sub_d   = sub_q;
`endif
    if (flush) begin
      state_d = LOAD_A;
      cnt_d   = '0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (accept) begin
            if (cnt_q == LAST_IDX) begin
              cnt_d   = '0;
              state_d = LOAD_B;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            if (cnt_q == LAST_IDX) begin
              cnt_d   = '0;
              state_d = HOLD;
`ifdef TREE_ADDER_SUB_EN
              sub_d   = in_sub;
              cin_d   = in_sub ? 1'b1 : in_cin;
`else
              cin_d   = in_cin;
`endif
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (op_valid_q && op_ready) begin
            state_d = LOAD_A;
          end
        end
        default: begin
          state_d = LOAD_A;
          cnt_d   = '0;
        end
      endcase
    end
    op_valid_d = (state_d == HOLD);
    in_ready_d = (state_d != HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD_A;
      cnt_q      <= '0;
      cin_q      <= 1'b0;
      op_valid_q <= 1'b0;
      in_ready_q <= 1'b0;
`ifdef TREE_ADDER_SUB_EN
      sub_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cin_q      <= cin_d;
      op_valid_q <= op_valid_d;
      in_ready_q <= in_ready_d;
`ifdef TREE_ADDER_SUB_EN
      sub_q      <= sub_d;
`endif
    end
  end

  beat_shift_slot #(
    .SIZE   (SIZE),
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS),
    .IDX_W  (IDX_W)
  ) u_slot_a (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (a_wr),
    .wr_idx  (cnt_q),
    .wr_data (in_data),
    .data    (a)
  );

  beat_shift_slot #(
    .SIZE   (SIZE),
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS),
    .IDX_W  (IDX_W)
  ) u_slot_b (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (b_wr),
    .wr_idx  (cnt_q),
    .wr_data (in_data),
    .data    (b_raw)
  );

`ifdef TREE_ADDER_SUB_EN
  assign b = sub_q ? ~b_raw : b_raw;
`else
  assign b = b_raw;
`endif

  assign cin      = cin_q;
  assign op_valid = op_valid_q;
  assign in_ready = in_ready_q;
  // B-phase beats count on top of the full A operand already received.
  assign beat_cnt = (state_q == LOAD_B) ? (BCNT_W'(BEATS) + BCNT_W'(cnt_q))
                                        : BCNT_W'(cnt_q);

endmodule

// File: tb/tb_tree_adder_operand_loader.sv
// Scoreboard bench for tree_adder_operand_loader (128-bit operands, 32-bit beats).
module tb_tree_adder_operand_loader;

  localparam int SIZE   = 128;
  localparam int BEAT_W = 32;
  localparam int BEATS  = SIZE / BEAT_W;

  typedef struct packed {
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            cin;
  } triple_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [BEAT_W-1:0] in_data;
  logic              in_cin;
  logic              in_sub;
  logic              flush;
  logic              op_valid;
  logic              op_ready;
  logic [SIZE:1]     a;
  logic [SIZE:1]     b;
  logic              cin;
  logic [2:0]        beat_cnt;

  triple_t exp_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tree_adder_operand_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_cin   (in_cin),
`ifdef TREE_ADDER_SUB_EN
    .in_sub   (in_sub),
`endif
    .flush    (flush),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .beat_cnt (beat_cnt)
  );

  // All tasks start and end just after a falling edge.
  task automatic send_beat(input logic [BEAT_W-1:0] d, input logic c, input logic s);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_cin   = c;
    in_sub   = s;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 50) begin
      errors++;
      $display("FAIL beat_timeout: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic triple_t model(input logic [SIZE-1:0] va, input logic [SIZE-1:0] vb,
                                    input logic c, input logic s);
    triple_t t;
    t.a   = va;
    t.b   = vb;
    t.cin = c;
`ifdef TREE_ADDER_SUB_EN
    if (s) begin
      t.b   = ~vb;
      t.cin = 1'b1;
    end
`else
    if (s) t.cin = c;
`endif
    return t;
  endfunction

  task automatic send_set(input logic [SIZE-1:0] va, input logic [SIZE-1:0] vb,
                          input logic c, input logic s);
    exp_q.push_back(model(va, vb, c, s));
    for (int k = 0; k < BEATS; k++) send_beat(va[k*BEAT_W +: BEAT_W], 1'b0, 1'b0);
    for (int k = 0; k < BEATS; k++) send_beat(vb[k*BEAT_W +: BEAT_W], c, s);
  endtask

  task automatic consume(input string name);
    int guard = 0;
    triple_t e;
    while (!op_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++;
      $display("FAIL %s_valid_timeout: op_valid=%0b required 1", name, op_valid);
    end
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_scoreboard_empty: size=0 required >0", name);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (a !== e.a) begin
        errors++;
        $display("FAIL %s_a: got %h required %h", name, a, e.a);
      end
      checks++;
      if (b !== e.b) begin
        errors++;
        $display("FAIL %s_b: got %h required %h", name, b, e.b);
      end
      checks++;
      if (cin !== e.cin) begin
        errors++;
        $display("FAIL %s_cin: got %0b required %0b", name, cin, e.cin);
      end
    end
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    checks++;
    if (op_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_handoff: op_valid=%0b in_ready=%0b required 0/1", name, op_valid, in_ready);
    end
    $display("txn %s: a=%h b=%h cin=%0b", name, a, b, cin);
  endtask

  task automatic check_reset_outputs(input string name, input logic exp_ready);
    checks++;
    if (op_valid !== 1'b0 || a !== '0 || b !== '0 || cin !== 1'b0 || in_ready !== exp_ready) begin
      errors++;
      $display("FAIL %s: op_valid=%0b a=%h b=%h cin=%0b in_ready=%0b required 0/0/0/0/%0b",
               name, op_valid, a, b, cin, in_ready, exp_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset_state", 1'b0);
    checks++;
    if (beat_cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_beat_cnt: got %0d required 0", beat_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %0b required 1", in_ready);
    end
    $display("txn reset: in_ready=%0b", in_ready);
  endtask

  task automatic test_basic_and_hold();
    logic [SIZE-1:0] va = 128'd1;
    logic [SIZE-1:0] vb = '1;
    send_set(va, vb, 1'b0, 1'b0);
    checks++;
    if (op_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: op_valid=%0b in_ready=%0b required 1/0", op_valid, in_ready);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (a !== va || b !== vb || op_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: a=%h b=%h op_valid=%0b in_ready=%0b", i, a, b, op_valid, in_ready);
      end
    end
    consume("basic");
  endtask

  task automatic test_toggle_valid();
    logic [SIZE-1:0] va = {$urandom, $urandom, $urandom, $urandom};
    logic [SIZE-1:0] vb = {$urandom, $urandom, $urandom, $urandom};
    logic [BEAT_W-1:0] d;
    exp_q.push_back(model(va, vb, 1'b1, 1'b0));
    for (int i = 0; i < 2*BEATS; i++) begin
      d = (i < BEATS) ? va[i*BEAT_W +: BEAT_W] : vb[(i-BEATS)*BEAT_W +: BEAT_W];
      in_valid = 1'b1;
      in_data  = d;
      in_cin   = 1'b1;
      in_sub   = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = ~d;
      if (i < 2*BEATS-1) begin
        checks++;
        if (beat_cnt !== 3'(i+1)) begin
          errors++;
          $display("FAIL toggle_cnt[%0d]: got %0d required %0d", i, beat_cnt, i+1);
        end
        @(negedge clk);
        checks++;
        if (beat_cnt !== 3'(i+1)) begin
          errors++;
          $display("FAIL toggle_idle[%0d]: got %0d required %0d", i, beat_cnt, i+1);
        end
      end
    end
    consume("toggle");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) send_beat(32'hDEAD_0000 | 32'(i), 1'b1, 1'b1);
    checks++;
    if (beat_cnt !== 3'd5) begin
      errors++;
      $display("FAIL flush_pre_cnt: got %0d required 5", beat_cnt);
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hBAD0_BAD0;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (beat_cnt !== 3'd0 || op_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: beat_cnt=%0d op_valid=%0b in_ready=%0b required 0/0/1",
               beat_cnt, op_valid, in_ready);
    end
    send_set({$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    consume("flush_clean");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) begin
      send_set({$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
      consume($sformatf("b2b%0d", n));
    end
  endtask

  task automatic test_flush_in_hold();
    for (int k = 0; k < 2*BEATS; k++) send_beat(32'h1234_5678, 1'b1, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (op_valid !== 1'b0 || in_ready !== 1'b1 || beat_cnt !== 3'd0) begin
      errors++;
      $display("FAIL flush_hold: op_valid=%0b in_ready=%0b beat_cnt=%0d required 0/1/0",
               op_valid, in_ready, beat_cnt);
    end
    $display("txn flush_hold: op_valid=%0b", op_valid);
  endtask

  task automatic test_rst_in_hold();
    for (int k = 0; k < 2*BEATS; k++) send_beat(32'hA5A5_5A5A, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_hold", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_hold_ready: got %0b required 1", in_ready);
    end
    $display("txn rst_hold: in_ready=%0b", in_ready);
  endtask

`ifdef TREE_ADDER_SUB_EN
  task automatic test_sub();
    logic [SIZE:0] sum;
    logic [SIZE:0] exp_sum;
    exp_sum = '0;
    exp_sum[SIZE] = 1'b1;
    exp_sum[1] = 1'b1;
    send_set(128'd5, 128'd3, 1'b0, 1'b1);
    sum = {1'b0, a} + {1'b0, b} + {{SIZE{1'b0}}, cin};
    checks++;
    if (sum !== exp_sum) begin
      errors++;
      $display("FAIL sub_sum: got %h required %h", sum, exp_sum);
    end
    consume("sub");
  endtask
`endif

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_cin   = 1'b0;
    in_sub   = 1'b0;
    flush    = 1'b0;
    op_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_and_hold();
    test_toggle_valid();
    test_flush();
    test_back_to_back();
    test_flush_in_hold();
    test_rst_in_hold();
`ifdef TREE_ADDER_SUB_EN
    test_sub();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
